// File: rtl/usb_pkg.sv
// usb_pkg: shared types and constants for the USB transmit path.
package usb_pkg;
    localparam int USB_STUFF_LIMIT = 6;
    typedef enum logic [2:0] {IDLE, START, SEND, STUFF, FIN} bitstuff_state_t;
endpackage

// File: rtl/usb_bitstuff_if.sv
// usb_bitstuff_if: serializer-side handshake and NRZI-side framing signals of the bit stuffer.
interface usb_bitstuff_if;
    logic start_stuff;
    logic s_in;
    logic bit_valid;
    logic last_in;
    logic bit_ready;
    logic s_out;
    logic start_nrzi;
    logic done;
    logic underrun;
    modport master (
        output start_stuff, s_in, bit_valid, last_in,
        input  bit_ready, s_out, start_nrzi, done, underrun
    );
    modport slave (
        input  start_stuff, s_in, bit_valid, last_in,
        output bit_ready, s_out, start_nrzi, done, underrun
    );
endinterface

// File: rtl/usb_bitstuff_fsm.sv
// bitstuff_fsm: packet sequencing for the bit stuffer and decode of its framing/handshake strobes.
module bitstuff_fsm
    import usb_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start_stuff_i,
    input  logic            hit_i,
    input  logic            last_i,
    input  logic            last_seen_i,
    output bitstuff_state_t state_o,
    output logic            bit_ready_o,
    output logic            start_nrzi_o,
    output logic            done_o
);
    bitstuff_state_t state_q, state_d;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = start_stuff_i ? START : IDLE;
            START:   state_d = SEND;
            // a stuff trigger wins over last_in so the trailing 0 is never dropped
            SEND:    state_d = hit_i ? STUFF : last_i ? FIN : SEND;
            STUFF:   state_d = last_seen_i ? FIN : SEND;
            default: state_d = IDLE;
        endcase
    end
    assign state_o      = state_q;
    assign bit_ready_o  = state_q == SEND;
    assign start_nrzi_o = state_q == START;
    assign done_o       = state_q == FIN;
endmodule

// File: rtl/usb_bitstuff.sv
// usb_bitstuff: inserts a 0 after every STUFF_LIMIT consecutive 1s of the raw transmit stream
// and frames the stuffed stream for the NRZI encoder.
module usb_bitstuff
    import usb_pkg::*;
#(
    parameter int STUFF_LIMIT = USB_STUFF_LIMIT
) (
    input logic           clk,
    input logic           rst,
    usb_bitstuff_if.slave bus
);
    localparam int CW = $clog2(STUFF_LIMIT + 1);
    bitstuff_state_t state;
    logic [CW-1:0] ones_cnt_q, ones_cnt_d;
    logic s_out_q, s_out_d;
    logic last_seen_q, last_seen_d;
    logic underrun_q, underrun_d;
    logic one, hit;
    // an underrun bit is consumed as a 0, so it breaks any run of ones
    assign one = state == SEND && bus.bit_valid && bus.s_in;
    assign hit = one && ones_cnt_q == CW'(STUFF_LIMIT - 1);
    bitstuff_fsm u_fsm (
        .clk          (clk),
        .rst          (rst),
        .start_stuff_i(bus.start_stuff),
        .hit_i        (hit),
        .last_i       (bus.last_in),
        .last_seen_i  (last_seen_q),
        .state_o      (state),
        .bit_ready_o  (bus.bit_ready),
        .start_nrzi_o (bus.start_nrzi),
        .done_o       (bus.done)
    );
    always_comb begin
        s_out_d     = one;
        ones_cnt_d  = (one && !hit) ? ones_cnt_q + CW'(1) : '0;
        last_seen_d = state == SEND ? bus.last_in : last_seen_q;
        underrun_d  = (state == IDLE && bus.start_stuff) ? 1'b0 :
                      (state == SEND && !bus.bit_valid) ? 1'b1 : underrun_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_out_q     <= 1'b0;
            ones_cnt_q  <= '0;
            last_seen_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            s_out_q     <= s_out_d;
            ones_cnt_q  <= ones_cnt_d;
            last_seen_q <= last_seen_d;
            underrun_q  <= underrun_d;
        end
    end
    assign bus.s_out    = s_out_q;
    assign bus.underrun = underrun_q;
endmodule

// File: tb/tb_usb_bitstuff.sv
// tb_usb_bitstuff: directed packet vectors with hand-computed stuffed streams for usb_bitstuff.
module tb_usb_bitstuff;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    int max_cnt = 0;
    usb_bitstuff_if bus();
    usb_bitstuff dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(negedge clk) if (int'(dut.ones_cnt_q) > max_cnt) max_cnt = int'(dut.ones_cnt_q);
    typedef struct {
        string name;
        string raw;
        string exp;
        int    stuffs;
        int    stall_at;
        int    start_at;
    } vec_t;
    vec_t vecs[$];
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic check_str(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %s expected %s", name, act, exp);
        end
    endtask
    task automatic run_packet(input vec_t v);
        int idx, cyc, lows, n, scyc;
        bit prev_rv, done_seen, valid;
        string obs;
        n = v.raw.len();
        @(negedge clk);
        bus.start_stuff = 1'b1;
        @(negedge clk);
        bus.start_stuff = 1'b0;
        check({v.name, " start_nrzi"}, int'(bus.start_nrzi), 1);
        check({v.name, " ready in START"}, int'(bus.bit_ready), 0);
        check({v.name, " underrun cleared"}, int'(bus.underrun), 0);
        cyc = 1; idx = 0; lows = 0; obs = ""; prev_rv = 0; done_seen = 0;
        bus.s_in = v.raw[0] == "1";
        bus.last_in = n == 1;
        bus.bit_valid = 1'b1;
        while (!done_seen && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (prev_rv) idx++;
            if (cyc >= 3) obs = {obs, bus.s_out ? "1" : "0"};
            if (bus.done) done_seen = 1;
            else if (!bus.bit_ready) lows++;
            scyc = cyc - 2;
            valid = scyc != v.stall_at;
            bus.bit_valid = valid;
            bus.s_in = idx < n && v.raw[idx] == "1";
            bus.last_in = idx == n - 1;
            bus.start_stuff = scyc == v.start_at;
            prev_rv = bus.bit_ready && valid;
        end
        bus.start_stuff = 1'b0;
        bus.bit_valid = 1'b0;
        bus.s_in = 1'b0;
        bus.last_in = 1'b0;
        check({v.name, " done seen"}, int'(done_seen), 1);
        check({v.name, " total cycles"}, cyc + 1, n + v.stuffs + (v.stall_at >= 0 ? 1 : 0) + 3);
        check_str({v.name, " stream"}, obs, v.exp);
        check({v.name, " ready-low cycles"}, lows, v.stuffs);
        @(negedge clk);
        check({v.name, " done one cycle"}, int'(bus.done), 0);
        check({v.name, " idle s_out"}, int'(bus.s_out), 0);
        check({v.name, " underrun sticky"}, int'(bus.underrun), v.stall_at >= 0 ? 1 : 0);
    endtask
    initial begin
        int waited, any_done;
        vecs.push_back('{"sync",     "000000010",    "000000010",      0, -1, -1});
        vecs.push_back('{"single",   "11111110",     "111111010",      1, -1, -1});
        vecs.push_back('{"twelve",   "111111111111", "11111101111110", 2, -1, -1});
        vecs.push_back('{"trailing", "0111111",      "01111110",       1, -1, -1});
        vecs.push_back('{"five_six", "1111101111110", "11111011111100", 1, -1, -1});
        vecs.push_back('{"alt",      "1010",         "1010",           0, -1, -1});
        vecs.push_back('{"underrun", "101100",       "1001100",        0,  2,  3});
        bus.start_stuff = 1'b0;
        bus.s_in = 1'b0;
        bus.bit_valid = 1'b0;
        bus.last_in = 1'b0;
        rst = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        check("reset s_out", int'(bus.s_out), 0);
        check("reset start_nrzi", int'(bus.start_nrzi), 0);
        check("reset done", int'(bus.done), 0);
        check("reset bit_ready", int'(bus.bit_ready), 0);
        check("reset underrun", int'(bus.underrun), 0);
        rst = 1'b0;
        foreach (vecs[i]) run_packet(vecs[i]);
        @(negedge clk);
        bus.start_stuff = 1'b1;
        @(negedge clk);
        bus.start_stuff = 1'b0;
        bus.s_in = 1'b1;
        bus.bit_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (bus.bit_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("reached STUFF", int'(waited < 20), 1);
        check("STUFF s_out before reset", int'(bus.s_out), 1);
        rst = 1'b1;
        #1;
        check("midrst s_out", int'(bus.s_out), 0);
        check("midrst bit_ready", int'(bus.bit_ready), 0);
        check("midrst done", int'(bus.done), 0);
        bus.s_in = 1'b0;
        bus.bit_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        any_done = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done) any_done = 1;
        end
        check("no done after reset", any_done, 0);
        run_packet('{"post_reset", "1111110", "11111100", 1, -1, -1});
        check("ones_cnt bound", int'(max_cnt > 6), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
